// File: rtl/game_pkg.sv
// Shared game-side definitions for the ball hand-off I2C link.
// Holds the sender FSM state encoding, the frame length and the register pointer.
// No ports; imported by ball_i2c_sender.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    ACK,
    STOP,
    DONE
  } i2c_state_t;

  // Bytes per frame: address, register pointer, y_hi, y_lo, vy, gravity, speed.
  localparam int         FRAME_LEN = 7;
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN - 1);
  localparam logic [7:0] REG_PTR   = 8'h00;

endpackage

// File: rtl/i2c_tick_gen.sv
// Purpose: free-running quarter-SCL-period tick generator (0..CLK_DIV-1).
// Latency: tick is combinational from the count; restart zeroes the count on the next edge.
// Backpressure: none, free running.
// Ports: clk_25MHZ/reset (async, active high), restart (sync counter clear),
//        tick (one-cycle pulse on the last cycle of every quarter).
module i2c_tick_gen #(
  parameter int CLK_DIV = 62
) (
  input  logic clk_25MHZ,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ball_i2c_sender.sv
// Purpose: I2C master that writes one 7-byte ball hand-off frame to the opposing board.
// Latency: (4 + 7*36 + 4) * CLK_DIV + 2 cycles from trigger edge to done pulse (all bytes ACKed).
// Backpressure: trigger is a held level; only its rising edge in IDLE starts a frame; NACK aborts.
// Ports: clk_25MHZ, reset (async, active high); ball_send_trigger, ball_y, ball_vy,
//        gravity_counter, ball_fast (frame payload, latched at start); sda_in (line sample);
//        scl_oe/sda_oe (1 = pull low); busy; is_i2c_master_done (pulse); ack_error.
module ball_i2c_sender
  import game_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h30,
  parameter int         CLK_DIV    = 62
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic       ball_send_trigger,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_vy,
  input  logic [1:0] gravity_counter,
  input  logic       ball_fast,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       is_i2c_master_done,
  output logic       ack_error
);

  i2c_state_t state, state_nxt;

  logic       trig_prev;
  logic       start_evt;
  logic       tick;
  logic       q_end;
  logic [1:0] qtr;
  logic [2:0] bit_cnt;
  logic [2:0] byte_cnt;
  logic       ack_nack;
  logic [1:0] sda_sync;
  logic [9:0] y_l;
  logic [7:0] vy_l;
  logic [1:0] grav_l;
  logic       fast_l;
  logic [7:0] cur_byte;
  logic       cur_bit;
  logic       scl_oe_nxt, sda_oe_nxt, busy_nxt, done_nxt;

  assign start_evt = (state == IDLE) && ball_send_trigger && !trig_prev;
  assign q_end     = tick && (qtr == 2'd3);

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_25MHZ (clk_25MHZ),
    .reset     (reset),
    .restart   (start_evt),
    .tick      (tick)
  );

  always_comb begin
    cur_byte = REG_PTR;
    case (byte_cnt)
      3'd0:    cur_byte = {SLAVE_ADDR, 1'b0};
      3'd1:    cur_byte = REG_PTR;
      3'd2:    cur_byte = {y_l[9:8], 6'b0};
      3'd3:    cur_byte = y_l[7:0];
      3'd4:    cur_byte = vy_l;
      3'd5:    cur_byte = {6'b0, grav_l};
      3'd6:    cur_byte = {7'b0, fast_l};
      default: cur_byte = REG_PTR;
    endcase
  end

  assign cur_bit = cur_byte[bit_cnt];

  // Next state and the line levels for the current quarter. Line levels are
  // registered below so SCL/SDA never glitch on combinational decode.
  always_comb begin
    state_nxt  = state;
    scl_oe_nxt = 1'b0;
    sda_oe_nxt = 1'b0;
    busy_nxt   = 1'b1;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start_evt) state_nxt = START;
      end
      START: begin
        // SDA falls halfway through with SCL still released.
        sda_oe_nxt = qtr[1];
        if (q_end) state_nxt = DATA;
      end
      DATA: begin
        scl_oe_nxt = (qtr == 2'd0) || (qtr == 2'd3);
        sda_oe_nxt = !cur_bit;
        if (q_end && (bit_cnt == 3'd0)) state_nxt = ACK;
      end
      ACK: begin
        scl_oe_nxt = (qtr == 2'd0) || (qtr == 2'd3);
        if (q_end) begin
          if (ack_nack || (byte_cnt == LAST_BYTE)) state_nxt = STOP;
          else                                     state_nxt = DATA;
        end
      end
      STOP: begin
        scl_oe_nxt = (qtr == 2'd0);
        sda_oe_nxt = (qtr != 2'd3);
        if (q_end) state_nxt = DONE;
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      trig_prev          <= 1'b0;
      scl_oe             <= 1'b0;
      sda_oe             <= 1'b0;
      busy               <= 1'b0;
      is_i2c_master_done <= 1'b0;
      ack_error          <= 1'b0;
      qtr                <= 2'd0;
      bit_cnt            <= 3'd0;
      byte_cnt           <= 3'd0;
      ack_nack           <= 1'b0;
      sda_sync           <= 2'b11;
      y_l                <= 10'd0;
      vy_l               <= 8'd0;
      grav_l             <= 2'd0;
      fast_l             <= 1'b0;
    end else begin
      state              <= state_nxt;
      trig_prev          <= ball_send_trigger;
      scl_oe             <= scl_oe_nxt;
      sda_oe             <= sda_oe_nxt;
      busy               <= busy_nxt;
      is_i2c_master_done <= done_nxt;
      // The bus is asynchronous to us; two flops ahead of the ACK sample.
      // The extra delay stays well inside the SCL-high window.
      sda_sync           <= {sda_sync[0], sda_in};
      if (start_evt) begin
        qtr       <= 2'd0;
        bit_cnt   <= 3'd7;
        byte_cnt  <= 3'd0;
        ack_error <= 1'b0;
        ack_nack  <= 1'b0;
        y_l       <= ball_y;
        vy_l      <= ball_vy;
        grav_l    <= gravity_counter;
        fast_l    <= ball_fast;
      end else if (tick && (state != IDLE) && (state != DONE)) begin
        qtr <= qtr + 2'd1;
        if ((state == ACK) && (qtr == 2'd1)) ack_nack <= sda_sync[1];
        if (qtr == 2'd3) begin
          if ((state == DATA) && (bit_cnt != 3'd0)) bit_cnt <= bit_cnt - 3'd1;
          if (state == ACK) begin
            if (ack_nack) begin
              ack_error <= 1'b1;
            end else if (byte_cnt != LAST_BYTE) begin
              byte_cnt <= byte_cnt + 3'd1;
              bit_cnt  <= 3'd7;
            end
          end
        end
      end
    end
  end

endmodule
